// File: rtl/br_lite_local_ni.sv
// Network interface between a PE and the BR_LOCAL port of a BrLite router.
// TX side injects buffered PE broadcasts; RX side buffers router deliveries.
package br_lite_pkg;
   localparam int unsigned BR_ID_W = 4;
   localparam logic [1:0] BR_SVC_ALL = 2'd0;
   localparam logic [1:0] BR_SVC_TGT = 2'd1;
   localparam logic [1:0] BR_SVC_MON = 2'd2;

   typedef struct packed {
      logic [1:0]         service;
      logic [15:0]        seq_target;
      logic [15:0]        seq_source;
      logic [BR_ID_W-1:0] id;
      logic [31:0]        payload;
   } br_data_t;
endpackage

module br_lite_local_ni
   import br_lite_pkg::*;
#(
   parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
   parameter int unsigned TX_DEPTH    = 4,
   parameter int unsigned RX_DEPTH    = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   input  br_data_t           tx_data_i,
   output logic               rx_valid_o,
   input  logic               rx_ready_i,
   output br_data_t           rx_data_o,
   output br_data_t           flit_o,
   output logic               req_o,
   input  logic               ack_i,
   input  br_data_t           flit_i,
   input  logic               req_i,
   output logic               ack_o,
   input  logic               local_busy_i,
   output logic [BR_ID_W-1:0] tx_id_o
);
   localparam int unsigned TX_AW = $clog2(TX_DEPTH);
   localparam int unsigned RX_AW = $clog2(RX_DEPTH);

   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_REQ = 2'd1, TX_WAIT = 2'd2} tx_state_t;
   typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_ACK = 1'b1} rx_state_t;

   br_data_t        tx_mem_r [TX_DEPTH];
   br_data_t        rx_mem_r [RX_DEPTH];
   logic [TX_AW:0]  tx_wr_ptr_r, tx_rd_ptr_r, tx_wr_ptr_s, tx_rd_ptr_s;
   logic [RX_AW:0]  rx_wr_ptr_r, rx_rd_ptr_r, rx_wr_ptr_s, rx_rd_ptr_s;
   tx_state_t       tx_state_r, tx_state_s;
   rx_state_t       rx_state_r, rx_state_s;
   logic            tx_push_s, tx_pop_s, tx_empty_s, tx_full_nxt_s, req_s;
   logic            rx_push_s, rx_pop_s, rx_full_s, rx_valid_nxt_s, ack_s;
   br_data_t        tx_entry_s, tx_head_s, flit_s;

   // TX FIFO bookkeeping; an MSB mismatch with equal low bits means full
   always_comb begin
      tx_push_s  = tx_valid_i && tx_ready_o;
      tx_empty_s = (tx_wr_ptr_r == tx_rd_ptr_r);
      tx_head_s  = tx_mem_r[tx_rd_ptr_r[TX_AW-1:0]];
      tx_entry_s = tx_data_i;
      tx_entry_s.seq_source = SEQ_ADDRESS;
      tx_entry_s.id         = tx_id_o;
      tx_wr_ptr_s = tx_push_s ? tx_wr_ptr_r + {{TX_AW{1'b0}}, 1'b1} : tx_wr_ptr_r;
      tx_rd_ptr_s = tx_pop_s  ? tx_rd_ptr_r + {{TX_AW{1'b0}}, 1'b1} : tx_rd_ptr_r;
      tx_full_nxt_s = (tx_wr_ptr_s[TX_AW] != tx_rd_ptr_s[TX_AW]) &&
                      (tx_wr_ptr_s[TX_AW-1:0] == tx_rd_ptr_s[TX_AW-1:0]);
   end

   // TX next-state: req_o is never withdrawn before the router acks
   always_comb begin
      tx_state_s = tx_state_r;
      req_s      = req_o;
      flit_s     = flit_o;
      tx_pop_s   = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (!tx_empty_s && !local_busy_i) begin
               tx_state_s = TX_REQ;
               req_s      = 1'b1;
               flit_s     = tx_head_s;
            end else begin
               req_s = 1'b0;
            end
         end
         TX_REQ: begin
            if (ack_i) begin
               tx_state_s = TX_WAIT;
               req_s      = 1'b0;
               tx_pop_s   = 1'b1;
            end else begin
               req_s = 1'b1;
            end
         end
         TX_WAIT: begin
            if (!ack_i) begin
               tx_state_s = TX_IDLE;
            end else begin
               tx_state_s = TX_WAIT;
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
            req_s      = 1'b0;
         end
      endcase
   end

   // TX state, handshake outputs, pointers and id counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_state_r  <= TX_IDLE;
         req_o       <= 1'b0;
         flit_o      <= '0;
         tx_wr_ptr_r <= '0;
         tx_rd_ptr_r <= '0;
         tx_ready_o  <= 1'b1;
         tx_id_o     <= '0;
      end else begin
         tx_state_r  <= tx_state_s;
         req_o       <= req_s;
         flit_o      <= flit_s;
         tx_wr_ptr_r <= tx_wr_ptr_s;
         tx_rd_ptr_r <= tx_rd_ptr_s;
         tx_ready_o  <= !tx_full_nxt_s;
         if (tx_push_s) begin
            tx_id_o <= tx_id_o + {{(BR_ID_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // TX storage
   always_ff @(posedge clk_i) begin
      if (tx_push_s) begin
         tx_mem_r[tx_wr_ptr_r[TX_AW-1:0]] <= tx_entry_s;
      end
   end

   // RX FIFO bookkeeping
   always_comb begin
      rx_full_s   = (rx_wr_ptr_r[RX_AW] != rx_rd_ptr_r[RX_AW]) &&
                    (rx_wr_ptr_r[RX_AW-1:0] == rx_rd_ptr_r[RX_AW-1:0]);
      rx_pop_s    = rx_valid_o && rx_ready_i;
      rx_data_o   = rx_mem_r[rx_rd_ptr_r[RX_AW-1:0]];
      rx_wr_ptr_s = rx_push_s ? rx_wr_ptr_r + {{RX_AW{1'b0}}, 1'b1} : rx_wr_ptr_r;
      rx_rd_ptr_s = rx_pop_s  ? rx_rd_ptr_r + {{RX_AW{1'b0}}, 1'b1} : rx_rd_ptr_r;
      rx_valid_nxt_s = (rx_wr_ptr_s != rx_rd_ptr_s);
   end

   // RX next-state: one push per req assertion, ack held until req drops
   always_comb begin
      rx_state_s = rx_state_r;
      ack_s      = ack_o;
      rx_push_s  = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (req_i && !rx_full_s) begin
               rx_state_s = RX_ACK;
               ack_s      = 1'b1;
               rx_push_s  = 1'b1;
            end else begin
               ack_s = 1'b0;
            end
         end
         RX_ACK: begin
            if (!req_i) begin
               rx_state_s = RX_IDLE;
               ack_s      = 1'b0;
            end else begin
               ack_s = 1'b1;
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
            ack_s      = 1'b0;
         end
      endcase
   end

   // RX state, ack and pointers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_state_r  <= RX_IDLE;
         ack_o       <= 1'b0;
         rx_wr_ptr_r <= '0;
         rx_rd_ptr_r <= '0;
         rx_valid_o  <= 1'b0;
      end else begin
         rx_state_r  <= rx_state_s;
         ack_o       <= ack_s;
         rx_wr_ptr_r <= rx_wr_ptr_s;
         rx_rd_ptr_r <= rx_rd_ptr_s;
         rx_valid_o  <= rx_valid_nxt_s;
      end
   end

   // RX storage
   always_ff @(posedge clk_i) begin
      if (rx_push_s) begin
         rx_mem_r[rx_wr_ptr_r[RX_AW-1:0]] <= flit_i;
      end
   end
endmodule

// File: tb/tb_br_lite_local_ni.sv
// Scoreboard bench for br_lite_local_ni: directed router/PE stimulus with
// queued expectations checked by independent TX and RX monitors.
module tb_br_lite_local_ni;
   import br_lite_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic     tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
   br_data_t tx_data = '0, rx_data, flit_o, flit_i = '0;
   logic     req_o, ack_i = 1'b0, req_i = 1'b0, ack_o, local_busy = 1'b0;
   logic [BR_ID_W-1:0] tx_id;

   br_lite_local_ni #(.SEQ_ADDRESS(16'h0003), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_data_i(tx_data),
      .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
      .flit_o(flit_o), .req_o(req_o), .ack_i(ack_i),
      .flit_i(flit_i), .req_i(req_i), .ack_o(ack_o),
      .local_busy_i(local_busy), .tx_id_o(tx_id)
   );

   int n_checks = 0;
   int n_fail = 0;
   br_data_t tx_q[$];
   br_data_t rx_q[$];
   logic [BR_ID_W-1:0] exp_id = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic br_data_t mk(input logic [1:0] svc, input logic [15:0] tgt,
                                   input logic [31:0] pay);
      br_data_t d;
      d = '0;
      d.service = svc; d.seq_target = tgt; d.payload = pay;
      d.seq_source = 16'hDEAD; d.id = 4'hF;
      return d;
   endfunction

   // TX monitor: flit must stay stable while req is up; compared when acked
   br_data_t held_flit;
   logic held_valid = 1'b0;
   always @(negedge clk) begin
      #1;
      if (rst_n && req_o) begin
         if (held_valid) check("tx_flit_stable", flit_o, held_flit);
         held_flit = flit_o;
         held_valid = 1'b1;
         if (ack_i) begin
            if (tx_q.size() == 0) check("tx_unexpected_pop", 1'b1, 1'b0);
            else check("tx_flit", flit_o, tx_q.pop_front());
            held_valid = 1'b0;
         end
      end else begin
         held_valid = 1'b0;
      end
   end

   // RX monitor: every PE pop is compared against the scoreboard
   always @(negedge clk) begin
      #1;
      if (rst_n && rx_valid && rx_ready) begin
         if (rx_q.size() == 0) check("rx_unexpected_pop", 1'b1, 1'b0);
         else check("rx_data", rx_data, rx_q.pop_front());
      end
   end

   task automatic push(input br_data_t d);
      br_data_t e;
      int n = 0;
      @(negedge clk);
      while (!tx_ready && n < 200) begin @(negedge clk); n++; end
      check("push_ready", tx_ready, 1'b1);
      if (tx_ready) begin
         tx_valid = 1'b1; tx_data = d;
         e = d; e.seq_source = 16'h0003; e.id = exp_id;
         tx_q.push_back(e);
         exp_id = exp_id + 4'd1;
         @(negedge clk);
         tx_valid = 1'b0;
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!req_o && n < 200) begin @(negedge clk); n++; end
      check("req_wait", req_o, 1'b1);
   endtask

   task automatic tx_ack(input int delay);
      int n = 0;
      wait_req();
      repeat (delay) @(negedge clk);
      ack_i = 1'b1;
      @(negedge clk);
      while (req_o && n < 50) begin @(negedge clk); n++; end
      check("req_drop", req_o, 1'b0);
      ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic rx_send(input br_data_t d, input int hold);
      int n = 0;
      @(negedge clk);
      flit_i = d; req_i = 1'b1;
      @(negedge clk);
      while (!ack_o && n < 200) begin @(negedge clk); n++; end
      check("rx_ack_rise", ack_o, 1'b1);
      if (ack_o) rx_q.push_back(d);
      repeat (hold) begin @(negedge clk); check("rx_ack_held", ack_o, 1'b1); end
      req_i = 1'b0;
      @(negedge clk);
      check("rx_ack_fall", ack_o, 1'b0);
   endtask

   br_data_t exp_s;
   logic [BR_ID_W-1:0] id_b, id_save;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tx_ready", tx_ready, 1'b1);
      check("rst_rx_valid", rx_valid, 1'b0);
      check("rst_req", req_o, 1'b0);
      check("rst_ack", ack_o, 1'b0);
      check("rst_tx_id", tx_id, 4'd0);
      rst_n = 1'b1;

      // single send
      push(mk(BR_SVC_ALL, 16'd5, 32'h0000_00AB));
      check("single_req_before", req_o, 1'b0);
      @(negedge clk);
      check("single_req_rise", req_o, 1'b1);
      exp_s = '0;
      exp_s.service = BR_SVC_ALL; exp_s.seq_target = 16'd5; exp_s.seq_source = 16'd3;
      exp_s.id = 4'd0; exp_s.payload = 32'hAB;
      check("single_flit", flit_o, exp_s);
      repeat (3) @(negedge clk);
      ack_i = 1'b1;
      @(negedge clk);
      check("single_req_fall", req_o, 1'b0);
      ack_i = 1'b0;
      @(negedge clk);
      check("single_tx_id", tx_id, 4'd1);
      check("single_tx_empty", tx_q.size(), 0);

      // busy gating
      push(mk(BR_SVC_ALL, 16'd7, 32'h1111));
      id_b = exp_id;
      push(mk(BR_SVC_TGT, 16'd8, 32'h2222));
      wait_req();
      repeat (4) @(negedge clk);
      ack_i = 1'b1; local_busy = 1'b1;
      @(negedge clk);
      check("busy_first_drop", req_o, 1'b0);
      ack_i = 1'b0;
      repeat (19) begin @(negedge clk); check("busy_hold_req", req_o, 1'b0); end
      local_busy = 1'b0;
      @(negedge clk);
      check("busy_release_req", req_o, 1'b1);
      check("busy_second_id", flit_o.id, id_b);
      tx_ack(4);

      // no-ack retry
      push(mk(BR_SVC_MON, 16'd9, 32'h3333));
      wait_req();
      repeat (50) begin @(negedge clk); check("noack_req_high", req_o, 1'b1); end
      ack_i = 1'b1;
      @(negedge clk);
      check("noack_req_fall", req_o, 1'b0);
      ack_i = 1'b0;
      repeat (5) @(negedge clk);
      check("noack_no_rereq", req_o, 1'b0);
      check("noack_single_pop", tx_q.size(), 0);

      // RX both styles
      rx_send(mk(BR_SVC_TGT, 16'd3, 32'hA5A5_0001), 3);
      check("rx_valid_a", rx_valid, 1'b1);
      rx_send(mk(BR_SVC_ALL, 16'd1, 32'hA5A5_0002), 0);
      rx_ready = 1'b1;
      repeat (4) @(negedge clk);
      rx_ready = 1'b0;
      check("rx_styles_drained", rx_q.size(), 0);
      check("rx_styles_empty", rx_valid, 1'b0);

      // RX backpressure
      for (int i = 0; i < 4; i++) rx_send(mk(BR_SVC_ALL, 16'd2, 32'hB000 + i), 0);
      @(negedge clk);
      flit_i = mk(BR_SVC_MON, 16'd3, 32'hB004); req_i = 1'b1;
      repeat (5) begin @(negedge clk); check("rx_bp_no_ack", ack_o, 1'b0); end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check("rx_bp_pop_edge", ack_o, 1'b0);
      @(negedge clk);
      check("rx_bp_ack", ack_o, 1'b1);
      if (ack_o) rx_q.push_back(flit_i);
      req_i = 1'b0;
      @(negedge clk);
      check("rx_bp_ack_fall", ack_o, 1'b0);
      rx_ready = 1'b1;
      repeat (6) @(negedge clk);
      rx_ready = 1'b0;
      check("rx_bp_drained", rx_q.size(), 0);
      check("rx_bp_empty", rx_valid, 1'b0);

      // TX full, ignored push, id wrap
      local_busy = 1'b1;
      for (int i = 0; i < 4; i++) push(mk(BR_SVC_ALL, 16'd4, 32'hC000 + i));
      check("full_ready_low", tx_ready, 1'b0);
      id_save = exp_id;
      check("full_tx_id", tx_id, id_save);
      tx_valid = 1'b1; tx_data = mk(BR_SVC_ALL, 16'd4, 32'hDEAD);
      @(negedge clk);
      tx_valid = 1'b0;
      check("full_push_ignored_id", tx_id, id_save);
      check("full_still_full", tx_ready, 1'b0);
      local_busy = 1'b0;
      repeat (4) tx_ack(1);
      check("full_drained", tx_q.size(), 0);
      id_save = tx_id;
      for (int i = 0; i < 16; i++) begin
         push(mk(BR_SVC_ALL, 16'd6, 32'hE000 + i));
         tx_ack(0);
      end
      check("wrap_id", tx_id, id_save);
      check("wrap_drained", tx_q.size(), 0);

      // reset mid-request
      push(mk(BR_SVC_ALL, 16'd5, 32'hF00D));
      wait_req();
      rst_n = 1'b0;
      #1;
      check("midrst_req", req_o, 1'b0);
      check("midrst_tx_id", tx_id, 4'd0);
      check("midrst_ready", tx_ready, 1'b1);
      tx_q.delete();
      exp_id = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("midrst_idle", req_o, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
